// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states,
// ALU operation selects, instruction field codes and datapath mux codes.
package mips_ctrl_pkg;

   typedef enum logic [4:0] {
      C_ADD_U = 5'd0,
      C_SUB_U = 5'd1,
      C_MULT  = 5'd2,
      C_MUL_U = 5'd3,
      C_AND   = 5'd4,
      C_OR    = 5'd5,
      C_XOR   = 5'd6,
      C_SRL   = 5'd7,
      C_SLL   = 5'd8,
      C_SRA   = 5'd9,
      C_SLT   = 5'd10,
      C_SLTU  = 5'd11,
      C_MFHI  = 5'd12,
      C_MFLO  = 5'd13,
      C_JR    = 5'd14,
      C_BEQ   = 5'd15,
      C_BNE   = 5'd16,
      C_BLEZ  = 5'd17,
      C_BGTZ  = 5'd18,
      C_BLTZ  = 5'd19,
      C_BGEZ  = 5'd20
   } alu_sel_t;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_R_EXEC   = 4'd2,
      S_R_WB     = 4'd3,
      S_I_EXEC   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_LW_READ  = 4'd7,
      S_LW_WB    = 4'd8,
      S_SW_WRITE = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   // Which family of ALU operation the current state needs.
   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_PC   = 3'd1,
      CLS_R    = 3'd2,
      CLS_I    = 3'd3,
      CLS_MEM  = 3'd4,
      CLS_BR   = 3'd5
   } ctrl_cls_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_SUBIU  = 6'h10;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
   localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU     = 2'b00;
   localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

   localparam logic [1:0] LOHI_ALU_OUT = 2'b00;
   localparam logic [1:0] LOHI_LO      = 2'b01;
   localparam logic [1:0] LOHI_HI      = 2'b10;

   function automatic logic funct_known(input logic [5:0] f);
      case (f)
         F_SLL, F_SRL, F_SRA, F_JR, F_MFHI, F_MFLO, F_MULT, F_MULTU,
         F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_SLT, F_SLTU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and branch flag in, all datapath
// enables and mux selects out. master = controller, slave = datapath.
interface mips_ctrl_if;
   import mips_ctrl_pkg::*;

   logic [5:0] ir_opcode;
   logic [4:0] ir_rt;
   logic [5:0] ir_funct;
   logic       branch_taken;

   alu_sel_t   opsel;
   logic       is_signed;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_source;
   logic       pc_en;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       jump_and_link;
   logic       hi_en;
   logic       lo_en;
   logic [1:0] alu_lo_hi;
   logic       halted;
   logic       illegal_op;

   modport master (
      input  ir_opcode, ir_rt, ir_funct, branch_taken,
      output opsel, is_signed, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
             mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
             jump_and_link, hi_en, lo_en, alu_lo_hi, halted, illegal_op
   );

   modport slave (
      output ir_opcode, ir_rt, ir_funct, branch_taken,
      input  opsel, is_signed, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
             mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
             jump_and_link, hi_en, lo_en, alu_lo_hi, halted, illegal_op
   );
endinterface

// File: rtl/mips_ctrl_alu_ctrl.sv
// Combinational ALU operation decode: state class plus opcode/funct/rt select
// the ALU operation and the immediate extension mode.
module mips_ctrl_alu_ctrl
   import mips_ctrl_pkg::*;
(
   input  ctrl_cls_t  cls,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   output alu_sel_t   opsel,
   output logic       is_signed
);

   always_comb begin
      opsel     = C_ADD_U;
      is_signed = 1'b0;
      case (cls)
         CLS_PC:  is_signed = 1'b1;
         CLS_MEM: is_signed = 1'b1;
         CLS_R: begin
            case (funct)
               F_ADDU:  opsel = C_ADD_U;
               F_SUBU:  opsel = C_SUB_U;
               F_MULT:  opsel = C_MULT;
               F_MULTU: opsel = C_MUL_U;
               F_AND:   opsel = C_AND;
               F_OR:    opsel = C_OR;
               F_XOR:   opsel = C_XOR;
               F_SRL:   opsel = C_SRL;
               F_SLL:   opsel = C_SLL;
               F_SRA:   opsel = C_SRA;
               F_SLT:   opsel = C_SLT;
               F_SLTU:  opsel = C_SLTU;
               F_MFHI:  opsel = C_MFHI;
               F_MFLO:  opsel = C_MFLO;
               F_JR:    opsel = C_JR;
               default: opsel = C_ADD_U;
            endcase
         end
         CLS_I: begin
            // Logical immediates are zero-extended, arithmetic/compare ones sign-extended.
            is_signed = !(opcode inside {OP_ANDI, OP_ORI, OP_XORI});
            case (opcode)
               OP_ADDIU: opsel = C_ADD_U;
               OP_SUBIU: opsel = C_SUB_U;
               OP_SLTI:  opsel = C_SLT;
               OP_SLTIU: opsel = C_SLTU;
               OP_ANDI:  opsel = C_AND;
               OP_ORI:   opsel = C_OR;
               OP_XORI:  opsel = C_XOR;
               default:  opsel = C_ADD_U;
            endcase
         end
         CLS_BR: begin
            case (opcode)
               OP_BEQ:    opsel = C_BEQ;
               OP_BNE:    opsel = C_BNE;
               OP_BLEZ:   opsel = C_BLEZ;
               OP_BGTZ:   opsel = C_BGTZ;
               OP_REGIMM: opsel = (rt == 5'd1) ? C_BGEZ : C_BLTZ;
               default:   opsel = C_BEQ;
            endcase
         end
         default: begin
            opsel     = C_ADD_U;
            is_signed = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_ctrl.sv
// Multi-cycle MIPS controller: walks each instruction through fetch, decode,
// execute, memory and writeback, driving every datapath enable.
//
// state      | meaning
// FETCH      | read instruction at PC; last cycle loads IR and PC+4
// DECODE     | branch target into alu_out, dispatch on opcode
// R_EXEC     | register-register ALU op (mult/JR finish here)
// R_WB       | write rd from alu_out / LO / HI
// I_EXEC     | register-immediate ALU op
// I_WB       | write rt from alu_out
// MEM_ADDR   | base + signed offset
// LW_READ    | data read at alu_out
// LW_WB      | write rt from MDR
// SW_WRITE   | single-cycle store
// BRANCH     | compare, conditional PC load from alu_out
// JUMP       | PC load from jump target (JAL also links r31)
// HALT       | parked until reset
module mips_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_RD_LAT  = 1,
   parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
   input logic         clk,
   input logic         rst,
   mips_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(MEM_RD_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_RD_LAT);

   state_t           state_q, state_d, dispatch_st;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wait_done;
   logic             dec_illegal;
   logic             is_mult, is_jr;

   logic       mem_read, mem_write, i_or_d, ir_write;
   logic       pc_write, pc_write_cond;
   logic       alu_src_a;
   logic [1:0] alu_src_b, pc_source, alu_lo_hi;
   logic       mem_to_reg, reg_dst, reg_write, jal;
   logic       hi_en, lo_en, halted, illegal_op;
   ctrl_cls_t  cls;

   assign wait_done = (cnt_q == LAT_C);
   assign is_mult   = (bus.ir_funct == F_MULT) || (bus.ir_funct == F_MULTU);
   assign is_jr     = (bus.ir_funct == F_JR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      dispatch_st = S_FETCH;
      dec_illegal = 1'b0;
      if (bus.ir_opcode == HALT_OPCODE) begin
         dispatch_st = S_HALT;
      end else begin
         case (bus.ir_opcode)
            OP_RTYPE: begin
               if (funct_known(bus.ir_funct)) dispatch_st = S_R_EXEC;
               else                           dec_illegal = 1'b1;
            end
            OP_LW, OP_SW:                                  dispatch_st = S_MEM_ADDR;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  dispatch_st = S_BRANCH;
            OP_J, OP_JAL:                                  dispatch_st = S_JUMP;
            OP_ADDIU, OP_SUBIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:                      dispatch_st = S_I_EXEC;
            default:                                       dec_illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (wait_done) state_d = S_DECODE;
         S_DECODE:   state_d = dispatch_st;
         S_R_EXEC:   state_d = (is_mult || is_jr) ? S_FETCH : S_R_WB;
         S_I_EXEC:   state_d = S_I_WB;
         S_MEM_ADDR: state_d = (bus.ir_opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
         S_LW_READ:  if (wait_done) state_d = S_LW_WB;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase

      // Counter restarts from zero on every state entry.
      if (state_d != state_q)
         cnt_d = '0;
      else if (!wait_done && (state_q == S_FETCH || state_q == S_LW_READ))
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end

   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALU_SRC_B_REG;
      pc_source     = PC_SRC_ALU;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      jal           = 1'b0;
      hi_en         = 1'b0;
      lo_en         = 1'b0;
      alu_lo_hi     = LOHI_ALU_OUT;
      halted        = 1'b0;
      illegal_op    = 1'b0;
      cls           = CLS_NONE;
      // Reset forces every output low so an aborted instruction cannot strobe.
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               if (wait_done) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  alu_src_b = ALU_SRC_B_FOUR;
                  cls       = CLS_PC;
               end
            end
            S_DECODE: begin
               alu_src_b  = ALU_SRC_B_IMM_SH;
               illegal_op = dec_illegal;
               cls        = CLS_PC;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               cls       = CLS_R;
               hi_en     = is_mult;
               lo_en     = is_mult;
               pc_write  = is_jr;
            end
            S_R_WB: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
               if (bus.ir_funct == F_MFHI)      alu_lo_hi = LOHI_HI;
               else if (bus.ir_funct == F_MFLO) alu_lo_hi = LOHI_LO;
            end
            S_I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_SRC_B_IMM;
               cls       = CLS_I;
            end
            S_I_WB:     reg_write = 1'b1;
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_SRC_B_IMM;
               cls       = CLS_MEM;
            end
            S_LW_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_LW_WB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
            end
            S_SW_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               pc_write_cond = 1'b1;
               pc_source     = PC_SRC_ALU_OUT;
               cls           = CLS_BR;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PC_SRC_JUMP;
               jal       = (bus.ir_opcode == OP_JAL);
               reg_write = (bus.ir_opcode == OP_JAL);
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   mips_ctrl_alu_ctrl u_alu_ctrl (
      .cls       (cls),
      .opcode    (bus.ir_opcode),
      .funct     (bus.ir_funct),
      .rt        (bus.ir_rt),
      .opsel     (bus.opsel),
      .is_signed (bus.is_signed)
   );

   assign bus.pc_en         = pc_write | (pc_write_cond & bus.branch_taken);
   assign bus.mem_read      = mem_read;
   assign bus.mem_write     = mem_write;
   assign bus.i_or_d        = i_or_d;
   assign bus.ir_write      = ir_write;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.pc_source     = pc_source;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.reg_dst       = reg_dst;
   assign bus.reg_write     = reg_write;
   assign bus.jump_and_link = jal;
   assign bus.hi_en         = hi_en;
   assign bus.lo_en         = lo_en;
   assign bus.alu_lo_hi     = alu_lo_hi;
   assign bus.halted        = halted;
   assign bus.illegal_op    = illegal_op;

endmodule

// File: tb/tb_mips_ctrl.sv
// Directed scoreboard bench for mips_ctrl at MEM_RD_LAT=1: expected per-cycle
// output vectors are queued with each instruction and compared cycle by cycle.
module tb_mips_ctrl;
   import mips_ctrl_pkg::*;

   typedef enum int {
      P_RST, P_F0, P_F1, P_DEC, P_DEC_ILL, P_R_EXEC, P_R_MULT, P_R_WB,
      P_I_EXEC, P_I_WB, P_MEM_ADDR, P_LW_RD, P_LW_WB, P_SW, P_BR, P_JAL, P_HALT
   } phase_t;

   typedef struct packed {
      logic       mem_read;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_source;
      logic       src_a;
      logic [1:0] src_b;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       jal;
      logic       hi_en;
      logic       lo_en;
      logic [1:0] lo_hi;
      logic       halted;
      logic       illegal;
      logic [4:0] opsel;
      logic       is_signed;
   } obs_t;

   typedef struct {
      phase_t     ph;
      alu_sel_t   op;
      logic [1:0] aux;
      string      tag;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mips_ctrl_if cif ();

   mips_ctrl #(.MEM_RD_LAT(1), .HALT_OPCODE(6'h3F)) dut (
      .clk (clk),
      .rst (rst),
      .bus (cif.master)
   );

   item_t sb[$];
   int    n_assert = 0;
   int    n_fail   = 0;
   int    n_push   = 0;
   logic  win_sw   = 1'b0;
   int    mw_seen  = 0;
   logic  win_ill  = 1'b0;
   int    ill_seen = 0;

   always @(negedge clk) begin
      if (win_sw && cif.mem_write)   mw_seen++;
      if (win_ill && cif.illegal_op) ill_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Reference outputs per phase, taken from the controller's state description.
   task automatic exp_of(input phase_t ph, input alu_sel_t op, input logic [1:0] aux,
                         output obs_t e, output obs_t m);
      e = '0;
      m = '1;
      m.opsel     = '0;
      m.is_signed = 1'b0;
      case (ph)
         P_RST: m = '1;
         P_F0:  e.mem_read = 1'b1;
         P_F1: begin
            e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_en = 1'b1;
            e.src_b = 2'b01; e.opsel = C_ADD_U; m.opsel = '1;
         end
         P_DEC, P_DEC_ILL: begin
            e.src_b = 2'b11; e.opsel = C_ADD_U; m.opsel = '1;
            e.illegal = (ph == P_DEC_ILL);
         end
         P_R_EXEC, P_R_MULT: begin
            e.src_a = 1'b1; e.opsel = op; m.opsel = '1;
            e.hi_en = (ph == P_R_MULT); e.lo_en = (ph == P_R_MULT);
         end
         P_R_WB: begin
            e.reg_dst = 1'b1; e.reg_write = 1'b1; e.lo_hi = aux;
         end
         P_I_EXEC: begin
            e.src_a = 1'b1; e.src_b = 2'b10; e.opsel = op; e.is_signed = aux[0];
            m.opsel = '1; m.is_signed = 1'b1;
         end
         P_I_WB: e.reg_write = 1'b1;
         P_MEM_ADDR: begin
            e.src_a = 1'b1; e.src_b = 2'b10; e.opsel = C_ADD_U; e.is_signed = 1'b1;
            m.opsel = '1; m.is_signed = 1'b1;
         end
         P_LW_RD: begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
         P_LW_WB: begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
         P_SW:    begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
         P_BR: begin
            e.src_a = 1'b1; e.pc_source = 2'b01; e.pc_en = aux[0];
            e.opsel = op; m.opsel = '1;
         end
         P_JAL: begin
            e.pc_en = 1'b1; e.pc_source = 2'b10; e.jal = 1'b1; e.reg_write = 1'b1;
         end
         P_HALT: e.halted = 1'b1;
         default: ;
      endcase
   endtask

   task automatic push(input phase_t ph, input alu_sel_t op = C_ADD_U,
                       input logic [1:0] aux = 2'b00);
      item_t it;
      it.ph  = ph;
      it.op  = op;
      it.aux = aux;
      it.tag = $sformatf("%s#%0d", ph.name(), n_push);
      n_push++;
      sb.push_back(it);
   endtask

   task automatic push_fetch();
      push(P_F0);
      push(P_F1);
      push(P_DEC);
   endtask

   task automatic drain();
      item_t       it;
      obs_t        o, e, m;
      logic [25:0] ov, ev;
      while (sb.size() > 0) begin
         @(negedge clk);
         it = sb.pop_front();
         o.mem_read   = cif.mem_read;
         o.i_or_d     = cif.i_or_d;
         o.ir_write   = cif.ir_write;
         o.pc_en      = cif.pc_en;
         o.pc_source  = cif.pc_source;
         o.src_a      = cif.alu_src_a;
         o.src_b      = cif.alu_src_b;
         o.mem_write  = cif.mem_write;
         o.mem_to_reg = cif.mem_to_reg;
         o.reg_dst    = cif.reg_dst;
         o.reg_write  = cif.reg_write;
         o.jal        = cif.jump_and_link;
         o.hi_en      = cif.hi_en;
         o.lo_en      = cif.lo_en;
         o.lo_hi      = cif.alu_lo_hi;
         o.halted     = cif.halted;
         o.illegal    = cif.illegal_op;
         o.opsel      = cif.opsel;
         o.is_signed  = cif.is_signed;
         exp_of(it.ph, it.op, it.aux, e, m);
         ov = o & m;
         ev = e & m;
         n_assert++;
         assert (ov === ev) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", it.tag, ov, ev);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_ir(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input logic br);
      cif.ir_opcode    = op;
      cif.ir_funct     = fn;
      cif.ir_rt        = rt;
      cif.branch_taken = br;
   endtask

   initial begin
      set_ir(6'h00, 6'h21, 5'd0, 1'b0);
      // 1: reset for 3 cycles, then ADDU
      push(P_RST); push(P_RST); push(P_RST);
      drain();
      rst = 1'b0;
      push_fetch(); push(P_R_EXEC, C_ADD_U); push(P_R_WB, C_ADD_U, 2'b00);
      drain();

      // 2: LW, two read cycles, 7 total
      set_ir(6'h23, 6'h00, 5'd0, 1'b0);
      push_fetch(); push(P_MEM_ADDR); push(P_LW_RD); push(P_LW_RD); push(P_LW_WB);
      drain();

      // 3: BEQ taken then not taken, then BGEZ not taken
      set_ir(6'h04, 6'h00, 5'd0, 1'b1);
      push_fetch(); push(P_BR, C_BEQ, 2'b01);
      drain();
      set_ir(6'h04, 6'h00, 5'd0, 1'b0);
      push_fetch(); push(P_BR, C_BEQ, 2'b00);
      drain();
      set_ir(6'h01, 6'h00, 5'd1, 1'b0);
      push_fetch(); push(P_BR, C_BGEZ, 2'b00);
      drain();

      // 4: MULT finishes in R_EXEC, MFHI writes back from HI
      set_ir(6'h00, 6'h18, 5'd0, 1'b0);
      push_fetch(); push(P_R_MULT, C_MULT);
      drain();
      set_ir(6'h00, 6'h10, 5'd0, 1'b0);
      push_fetch(); push(P_R_EXEC, C_MFHI); push(P_R_WB, C_ADD_U, 2'b10);
      drain();

      // I-type: ANDI zero-extends, ADDIU sign-extends
      set_ir(6'h0C, 6'h00, 5'd0, 1'b0);
      push_fetch(); push(P_I_EXEC, C_AND, 2'b00); push(P_I_WB);
      drain();
      set_ir(6'h09, 6'h00, 5'd0, 1'b0);
      push_fetch(); push(P_I_EXEC, C_ADD_U, 2'b01); push(P_I_WB);
      drain();

      // 5: JAL, then HALT held 20 cycles until reset
      set_ir(6'h03, 6'h00, 5'd0, 1'b0);
      push_fetch(); push(P_JAL);
      drain();
      set_ir(6'h3F, 6'h00, 5'd0, 1'b0);
      push_fetch();
      for (int i = 0; i < 20; i++) push(P_HALT);
      drain();
      rst = 1'b1;
      push(P_RST);
      drain();
      rst = 1'b0;

      // 6: SW aborted by reset in MEM_ADDR, then run to completion after release
      set_ir(6'h2B, 6'h00, 5'd0, 1'b0);
      push_fetch();
      drain();
      mw_seen = 0;
      win_sw  = 1'b1;
      rst = 1'b1;
      push(P_RST);
      drain();
      rst = 1'b0;
      push(P_F0);
      drain();
      win_sw = 1'b0;
      n_assert++;
      assert (mw_seen === 0) else begin
         n_fail++;
         $error("FAIL sw_abort_no_write observed=%0d required=0", mw_seen);
      end
      push(P_F1); push(P_DEC); push(P_MEM_ADDR); push(P_SW);
      drain();

      // Reset landing on the SW_WRITE cycle suppresses the strobe
      push_fetch(); push(P_MEM_ADDR);
      drain();
      rst = 1'b1;
      push(P_RST);
      drain();
      rst = 1'b0;

      // Illegal opcode pulses once, then fetch resumes
      set_ir(6'h15, 6'h00, 5'd0, 1'b0);
      ill_seen = 0;
      win_ill  = 1'b1;
      push(P_F0); push(P_F1); push(P_DEC_ILL); push(P_F0); push(P_F1);
      drain();
      win_ill = 1'b0;
      n_assert++;
      assert (ill_seen === 1) else begin
         n_fail++;
         $error("FAIL illegal_once observed=%0d required=1", ill_seen);
      end

      // Unknown funct is illegal with no write, back to fetch
      set_ir(6'h00, 6'h3F, 5'd0, 1'b0);
      push(P_DEC_ILL); push(P_F0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
